// File: rtl/ss_meas_sequencer_pkg.sv
// Shared types and helpers for the steady-state measurement sequencer.
package ss_meas_pkg;

  // Default sizing; the top-level parameters override these per instance.
  localparam int DEF_DW       = 10;
  localparam int DEF_AVG_LOG2 = 3;
  localparam int DEF_HOLD     = 2;
  localparam int DEF_TIMEOUT  = 1024;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_SS = 2'd1,
    ACCUM   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Ceiling log2 with a minimum of 1, so a counter sized by it always has at least one bit.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ss_meas_sequencer_if.sv
// Control, sample stream and result handshake between the sequencer and its environment.
interface ss_meas_sequencer_if #(
  parameter int DW = 10
);

  logic          start;
  logic          detect;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] res;
  logic          res_valid;
  logic          res_ready;
  logic          timeout;
  logic          busy;

  // Environment side: requests measurements, supplies samples, consumes results.
  modport master (
    output start, detect, din, din_valid, res_ready,
    input  res, res_valid, timeout, busy
  );

  // Sequencer side.
  modport slave (
    input  start, detect, din, din_valid, res_ready,
    output res, res_valid, timeout, busy
  );

endinterface

// File: rtl/ss_meas_sequencer_detect_sync.sv
// Two-flop synchronizer bringing the asynchronous detect flag into the clk domain.
module detect_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to resolve metastability.
  // NOTE: non-blocking assignments make both flops sample their old inputs on the same edge; blocking would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ss_meas_sequencer.sv
// Measurement sequencer: waits for a stable steady-state flag, averages 2**AVG_LOG2 samples,
// and returns the result (or a timeout abort) on a valid/ready port.
module ss_meas_sequencer
  import ss_meas_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int HOLD     = DEF_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic                 clk,
  input logic                 rstn,
  ss_meas_sequencer_if.slave  bus
);

  localparam int AW      = DW + AVG_LOG2;          // accumulator never overflows
  localparam int CW      = AVG_LOG2 + 1;           // sample counter
  localparam int HW      = clog2(HOLD + 1);        // hold counter
  localparam int TW      = clog2(TIMEOUT + 1);     // timer
  localparam int NUM_SMP = 1 << AVG_LOG2;

  localparam logic [CW-1:0] LAST_SMP  = CW'(NUM_SMP - 1);
  localparam logic [HW-1:0] HOLD_CNT  = HW'(HOLD);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   res_q, res_d;
  logic            res_valid_q, res_valid_d;
  logic            timeout_q, timeout_d;

  logic            det_s;
  logic [AW-1:0]   acc_sum;
  logic [HW-1:0]   hold_inc;
  logic            timer_hit;

  detect_sync u_detect_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.detect),
    .q    (det_s)
  );

  assign acc_sum   = acc_q + AW'(bus.din);
  assign hold_inc  = hold_q + 1'b1;
  assign timer_hit = (timer_q == TIMER_END);

  // Next-state, datapath and result computation for the sequencer FSM.
  // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    timer_d     = timer_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WAIT_SS;
          acc_d   = '0;
          cnt_d   = '0;
          hold_d  = '0;
          timer_d = TW'(1);      // first WAIT_SS cycle counts as 1
        end
      end

      WAIT_SS: begin
        timer_d = timer_q + 1'b1;
        if (timer_hit) begin
          state_d     = DONE;
          res_d       = '0;
          res_valid_d = 1'b1;
          timeout_d   = 1'b1;
        end else if (det_s) begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_CNT) begin
            state_d = ACCUM;
          end
        end else begin
          hold_d = '0;
        end
      end

      ACCUM: begin
        timer_d = timer_q + 1'b1;
        if (timer_hit) begin
          // Abort wins even over a final sample arriving this cycle.
          state_d     = DONE;
          res_d       = '0;
          res_valid_d = 1'b1;
          timeout_d   = 1'b1;
        end else if (!det_s) begin
          // Loss of steady state discards everything gathered, including a sample this cycle.
          state_d = WAIT_SS;
          acc_d   = '0;
          cnt_d   = '0;
          hold_d  = '0;
        end else if (bus.din_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SMP) begin
            state_d     = DONE;
            res_d       = DW'(acc_sum >> AVG_LOG2);
            res_valid_d = 1'b1;
            timeout_d   = 1'b0;
          end
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers; reset returns everything to zero at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      timer_q     <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      timer_q     <= timer_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ss_meas_sequencer.sv
// Directed self-checking bench for ss_meas_sequencer (DW=10, AVG_LOG2=3, HOLD=2, TIMEOUT=64).
module tb_ss_meas_sequencer;

  localparam int DW      = 10;
  localparam int BUDGET  = 200;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  ss_meas_sequencer_if #(.DW(DW)) bus ();

  ss_meas_sequencer #(
    .DW       (DW),
    .AVG_LOG2 (3),
    .HOLD     (2),
    .TIMEOUT  (64)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs held in reset, then released.
  task automatic test_reset();
    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.detect    = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.res !== '0 || bus.res_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: res=%0d valid=%b timeout=%b busy=%b, required all 0",
               bus.res, bus.res_valid, bus.timeout, bus.busy);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", bus.busy, bus.res_valid);
    end
  endtask

  // Detect already high, din=100 every cycle: result 100 at cycle 11.
  task automatic test_basic();
    int lat;
    lat = 0;
    bus.detect = 1'b1; bus.din = 10'd100; bus.din_valid = 1'b1; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d, required 11", lat); end
    checks++;
    if (bus.res !== 10'd100) begin errors++; $display("FAIL basic_res: got %0d, required 100", bus.res); end
    checks++;
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b, required 0", bus.timeout); end
    @(posedge clk); #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: valid=%b busy=%b, required 0 0", bus.res_valid, bus.busy);
    end
  endtask

  // Samples 0..7 on every other cycle from the first ACCUM cycle: floor(28/8)=3 at cycle 18.
  task automatic test_gapped();
    int lat;
    int bad_busy;
    lat = 0; bad_busy = 0;
    bus.detect = 1'b1; bus.din = '0; bus.din_valid = 1'b0; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
      if (bus.busy !== 1'b1) bad_busy++;
      if (k >= 3 && ((k - 3) % 2) == 0 && ((k - 3) / 2) < 8) begin
        bus.din_valid = 1'b1;
        bus.din       = DW'((k - 3) / 2);
      end else begin
        bus.din_valid = 1'b0;
      end
    end
    bus.din_valid = 1'b0;
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL gapped_latency: got %0d, required 18", lat); end
    checks++;
    if (bus.res !== 10'd3) begin errors++; $display("FAIL gapped_res: got %0d, required 3", bus.res); end
    checks++;
    if (bad_busy !== 0) begin errors++; $display("FAIL gapped_busy: %0d cycles low, required 0", bad_busy); end
    @(posedge clk); #1;
  endtask

  // Detect low for one cycle while accumulating 50s; the drop lands on the 8th sample and wins.
  // Accumulation restarts on 200s: result 200 at cycle 21.
  task automatic test_detect_drop();
    int lat;
    lat = 0;
    bus.detect = 1'b1; bus.din = 10'd50; bus.din_valid = 1'b1; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
      bus.detect = (k == 8) ? 1'b0 : 1'b1;
      bus.din    = (k <= 10) ? 10'd50 : 10'd200;
    end
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL drop_latency: got %0d, required 21", lat); end
    checks++;
    if (bus.res !== 10'd200) begin errors++; $display("FAIL drop_res: got %0d, required 200", bus.res); end
    checks++;
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL drop_timeout: got %b, required 0", bus.timeout); end
    @(posedge clk); #1;
  endtask

  // Detect held low: abort at cycle 65 with res=0, timeout=1.
  task automatic test_timeout();
    int lat;
    lat = 0;
    bus.detect = 1'b0; bus.din = 10'd77; bus.din_valid = 1'b1; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL timeout_latency: got %0d, required 65", lat); end
    checks++;
    if (bus.timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b, required 1", bus.timeout); end
    checks++;
    if (bus.res !== '0) begin errors++; $display("FAIL timeout_res: got %0d, required 0", bus.res); end
    @(posedge clk); #1;
  endtask

  // Seven samples early, the eighth in the very cycle the timer hits 64: timeout wins.
  task automatic test_timeout_vs_last();
    int lat;
    lat = 0;
    bus.detect = 1'b1; bus.din = 10'd8; bus.din_valid = 1'b0; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
      bus.din_valid = ((k >= 3 && k <= 9) || k == 64) ? 1'b1 : 1'b0;
    end
    bus.din_valid = 1'b0;
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL tvl_latency: got %0d, required 65", lat); end
    checks++;
    if (bus.timeout !== 1'b1 || bus.res !== '0) begin
      errors++;
      $display("FAIL tvl_result: timeout=%b res=%0d, required 1 0", bus.timeout, bus.res);
    end
    @(posedge clk); #1;
  endtask

  // Result held for 10 cycles of backpressure; start pulses in DONE and in the handshake cycle are ignored.
  task automatic test_backpressure();
    int lat;
    int unstable;
    lat = 0; unstable = 0;
    bus.detect = 1'b1; bus.din = 10'd100; bus.din_valid = 1'b1; bus.res_ready = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL bp_latency: got %0d, required 11", lat); end
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      bus.start = (j == 2) ? 1'b1 : 1'b0;
      if (bus.res !== 10'd100 || bus.res_valid !== 1'b1 || bus.timeout !== 1'b0 || bus.busy !== 1'b1)
        unstable++;
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", unstable); end
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: valid=%b busy=%b, required 0 0", bus.res_valid, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: busy=%b, required 0", bus.busy); end
  endtask

  // Reset mid-ACCUM clears outputs at once; a fresh run afterwards yields 37.
  task automatic test_async_reset();
    int lat;
    lat = 0;
    bus.detect = 1'b1; bus.din = 10'd100; bus.din_valid = 1'b1; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.res !== '0 || bus.res_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: res=%0d valid=%b timeout=%b busy=%b, required all 0",
               bus.res, bus.res_valid, bus.timeout, bus.busy);
    end
    @(negedge clk);
    rstn    = 1'b1;
    bus.din = 10'd37;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.res_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL rerun_latency: got %0d, required 11", lat); end
    checks++;
    if (bus.res !== 10'd37 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL rerun_res: res=%0d timeout=%b, required 37 0", bus.res, bus.timeout);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_detect_drop();
    test_timeout();
    test_timeout_vs_last();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
